// File: rtl/serial_arith_sequencer_if.sv
// serial_arith_sequencer_if: request/result bus plus the bit-slice hookup of the serial sequencer.
// The master side issues requests and hosts the external 1-bit arithmetic slice.
interface serial_arith_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       sel;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Cout;
    logic             overflow;
    logic             zero;
    logic             slice_Ai;
    logic             slice_Bi;
    logic             slice_Cini;
    logic [1:0]       slice_sel;
    logic             slice_Di;
    logic             slice_Couti;
    modport master (
        output start, A, B, sel, Cin, slice_Di, slice_Couti,
        input  busy, done, D, Cout, overflow, zero, slice_Ai, slice_Bi, slice_Cini, slice_sel
    );
    modport slave (
        input  start, A, B, sel, Cin, slice_Di, slice_Couti,
        output busy, done, D, Cout, overflow, zero, slice_Ai, slice_Bi, slice_Cini, slice_sel
    );
endinterface

// File: rtl/serial_arith_sequencer.sv
// serial_arith_sequencer: WIDTH-bit add/sub computed LSB-first through one external 1-bit slice.
// Define SERIAL_ARITH_FLAGS_EN to build the overflow/zero flag logic; otherwise both flags read 0.
module serial_arith_sequencer #(
    parameter int WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst,
    serial_arith_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_work, r_d;
    logic [1:0]       r_sel;
    logic             r_carry, r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_run, w_last, w_load;
    logic [WIDTH-1:0] w_res;

    assign w_run  = r_state == RUN;
    assign w_last = w_run && r_cnt == CW'(WIDTH - 1);
    assign w_load = r_state != RUN && bus.start;
    assign w_res  = {bus.slice_Di, r_work[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = IDLE;
        w_next = w_load ? RUN : w_last ? DONE : w_run ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sel   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_work  <= '0;
            r_sel   <= bus.sel;
            r_carry <= bus.Cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_work  <= w_res;
            r_carry <= bus.slice_Couti;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_d    <= w_res;
                r_cout <= bus.slice_Couti;
            end
        end
    end

`ifdef SERIAL_ARITH_FLAGS_EN
    logic r_ov, r_zero;
    // On the final edge r_carry is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_ov   <= bus.slice_Couti ^ r_carry;
            r_zero <= w_res == '0;
        end
    end
    assign bus.overflow = r_ov;
    assign bus.zero     = r_zero;
`else
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
`endif

    assign bus.busy       = w_run;
    assign bus.done       = r_state == DONE;
    assign bus.D          = r_d;
    assign bus.Cout       = r_cout;
    assign bus.slice_Ai   = w_run & r_a[0];
    assign bus.slice_Bi   = w_run & r_b[0];
    assign bus.slice_Cini = w_run & r_carry;
    assign bus.slice_sel  = w_run ? r_sel : 2'b00;
endmodule

// File: tb/tb_serial_arith_sequencer.sv
// tb_serial_arith_sequencer: directed vectors with a queue scoreboard and a behavioural 1-bit slice.
module tb_serial_arith_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
`ifdef SERIAL_ARITH_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic        co;
        logic        ov;
        logic        z;
        int          at;
    } exp_t;
    exp_t q[$];

    serial_arith_sequencer_if #(.WIDTH(32)) bus ();
    serial_arith_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic w_m;
    assign w_m = bus.slice_sel == 2'b00 ? 1'b0 : bus.slice_sel == 2'b01 ? bus.slice_Bi :
                 bus.slice_sel == 2'b10 ? ~bus.slice_Bi : 1'b1;
    assign bus.slice_Di    = bus.slice_Ai ^ w_m ^ bus.slice_Cini;
    assign bus.slice_Couti = (bus.slice_Ai & w_m) | (bus.slice_Ai & bus.slice_Cini) | (w_m & bus.slice_Cini);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("D", bus.D, e.d);
                chk("Cout", {31'd0, bus.Cout}, {31'd0, e.co});
                chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
                chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input logic c);
        bus.A   = a;
        bus.B   = b;
        bus.sel = s;
        bus.Cin = c;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input logic c,
                         input logic [31:0] d, input logic co, input logic ov, input logic z, input bit push);
        @(negedge clk);
        drive(a, b, s, c);
        bus.start = 1'b1;
        if (push) q.push_back('{d, co, ov & FL, z & FL, cyc + 33});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_D"}, bus.D, 32'd0);
        chk({tag, "_flags"}, {29'd0, bus.Cout, bus.overflow, bus.zero}, 32'd0);
        chk({tag, "_slice"}, {27'd0, bus.slice_Ai, bus.slice_Bi, bus.slice_Cini, bus.slice_sel}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        drive(32'd0, 32'd0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        issue(32'h5, 32'h3, 2'b01, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_run", {31'd0, bus.busy}, 32'd1);
        drain();
        issue(32'h3, 32'h5, 2'b10, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        issue(32'h1234, 32'h1234, 2'b10, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        issue(32'h7FFF_FFFF, 32'h0, 2'b00, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        issue(32'h0, 32'h0, 2'b11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        issue(32'hFFFF_FFFF, 32'h1, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        issue(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain();
        // A start pulse mid-run with different operands must not disturb the result.
        issue(32'd10, 32'd20, 2'b01, 1'b0, 32'h1E, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        drive(32'd99, 32'd1, 2'b11, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        chk("D_held", bus.D, 32'h1E);
        @(negedge clk);
        drive(32'h1234_5678, 32'h1111_1111, 2'b01, 1'b1);
        bus.start = 1'b1;
        q.push_back('{32'h2345_678A, 1'b0, 1'b0, 1'b0, cyc + 33});
        q.push_back('{32'h2345_678A, 1'b0, 1'b0, 1'b0, cyc + 66});
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        drain();
        issue(32'hAAAA_AAAA, 32'h1, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'h100, 32'h1, 2'b10, 1'b1, 32'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
